// File: rtl/lsu_mem_master.sv
// lsu_mem_master: CPU load/store initiator with lane steering, extension, timeout; optional split beats via MISALIGN_SPLIT_EN
module lsu_mem_master #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_i,
  output logic              cpu_ready_o,
  input  logic              cpu_we_i,
  input  logic [1:0]        cpu_size_i,
  input  logic              cpu_unsigned_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic              cpu_done_o,
  output logic              cpu_err_o,
  output logic [31:0]       cpu_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-3:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
`ifdef MISALIGN_SPLIT_EN
    ACC2 = 2'd2,
`endif
    DONE = 2'd3
  } state_t;
  state_t            state_q, state_d;
  logic [1:0]        size_q, size_d, o_q, o_d;
  logic              uns_q, uns_d, err_q, err_d;
  logic [3:0]        be2_q, be2_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
`ifdef MISALIGN_SPLIT_EN
  logic [31:0]       r1_q, r1_d;
`endif
  logic [1:0]  o;
  logic [31:0] wm, rot, sh, ld;
  logic [63:0] dbl, pair;
  logic [7:0]  be8;
  logic        split, to, more;
  // request-side steering: masked data rotated into its lanes, byte enables spanning two words
  always_comb begin
    o     = cpu_addr_i[1:0];
    wm    = cpu_size_i[1] ? cpu_wdata_i : cpu_size_i[0] ? {16'b0, cpu_wdata_i[15:0]} : {24'b0, cpu_wdata_i[7:0]};
    dbl   = {wm, wm} << {o, 3'b0};
    rot   = dbl[63:32];
    be8   = {4'b0, cpu_size_i[1] ? 4'b1111 : cpu_size_i[0] ? 4'b0011 : 4'b0001} << o;
    split = be8[7:4] != 4'b0;
  end
  // response side: assemble the (possibly two-word) read, shift down and extend; timeout detect
  always_comb begin
`ifdef MISALIGN_SPLIT_EN
    pair = state_q == ACC2 ? {mem_rdata_i, r1_q} : {32'b0, mem_rdata_i};
    more = state_q == ACC1 && be2_q != 4'b0;
`else
    pair = {32'b0, mem_rdata_i};
    more = 1'b0;
`endif
    sh = pair[31:0] >> {o_q, 3'b0} | pair[63:32] << (6'd32 - {1'b0, o_q, 3'b0});
    sh = o_q == 2'd0 ? pair[31:0] : sh;
    ld = size_q[1] ? sh : size_q[0] ? {{16{~uns_q & sh[15]}}, sh[15:0]} : {{24{~uns_q & sh[7]}}, sh[7:0]};
    to = TIMEOUT != 0 && {{(32-CW){1'b0}}, cnt_q} + 32'd1 >= 32'(TIMEOUT);
  end
  // next-state and registered memory-side outputs
  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    o_d         = o_q;
    uns_d       = uns_q;
    err_d       = err_q;
    be2_d       = be2_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
`ifdef MISALIGN_SPLIT_EN
    r1_d        = r1_q;
`endif
    if (state_q == IDLE) begin
      if (cpu_req_i) begin
        size_d      = cpu_size_i;
        o_d         = o;
        uns_d       = cpu_unsigned_i;
        be2_d       = be8[7:4];
        rdata_d     = 32'b0;
        cnt_d       = '0;
        mem_we_d    = cpu_we_i;
        mem_addr_d  = cpu_addr_i[ADDR_W-1:2];
        mem_be_d    = be8[3:0];
        mem_wdata_d = rot;
`ifdef MISALIGN_SPLIT_EN
        err_d       = 1'b0;
        state_d     = ACC1;
        mem_req_d   = 1'b1;
`else
        err_d       = split;
        state_d     = split ? DONE : ACC1;
        mem_req_d   = ~split;
`endif
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (mem_ack_i && more) begin
`ifdef MISALIGN_SPLIT_EN
      state_d    = ACC2;
      r1_d       = mem_rdata_i;
      mem_addr_d = mem_addr_q + (ADDR_W-2)'(1);
      mem_be_d   = be2_q;
      cnt_d      = '0;
`endif
    end else if (mem_ack_i || to) begin
      state_d     = DONE;
      err_d       = ~mem_ack_i;
      rdata_d     = mem_ack_i && !mem_we_q ? ld : 32'b0;
      mem_req_d   = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_be_d    = 4'b0;
      mem_wdata_d = 32'b0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end
  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      size_q      <= 2'b0;
      o_q         <= 2'b0;
      uns_q       <= 1'b0;
      err_q       <= 1'b0;
      be2_q       <= 4'b0;
      rdata_q     <= 32'b0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0;
      mem_wdata_q <= 32'b0;
`ifdef MISALIGN_SPLIT_EN
      r1_q        <= 32'b0;
`endif
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      o_q         <= o_d;
      uns_q       <= uns_d;
      err_q       <= err_d;
      be2_q       <= be2_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef MISALIGN_SPLIT_EN
      r1_q        <= r1_d;
`endif
    end
  end
  assign cpu_ready_o = state_q == IDLE;
  assign cpu_done_o  = state_q == DONE;
  assign cpu_err_o   = cpu_done_o & err_q;
  assign cpu_rdata_o = cpu_done_o ? rdata_q : 32'b0;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;
endmodule
